// File: rtl/aes_dec_fetch_ctrl.sv
// Sequencer between the ciphertext/key ROM and an AES-128 decryption core.
// Fetches block by block, loads the core, and hands each plaintext downstream.
module aes_dec_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int TEXT_WIDTH  = 128,
  parameter int KEY_WIDTH   = 128,
  parameter int MEMORY_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   num_blocks_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  input  logic [TEXT_WIDTH-1:0] rom_text_i,
  input  logic [KEY_WIDTH-1:0]  rom_key_i,
  output logic                  core_load_o,
  output logic [TEXT_WIDTH-1:0] core_text_o,
  output logic [KEY_WIDTH-1:0]  core_key_o,
  input  logic                  core_done_i,
  input  logic [TEXT_WIDTH-1:0] core_plain_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [TEXT_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH-1:0] out_index_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_WAIT_CORE = 3'd3;
  localparam logic [2:0] S_OUTPUT    = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_MAX  = MEMORY_SIZE;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE   = 1;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_out_index;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_num_blocks;
  logic [TEXT_WIDTH-1:0] r_core_text;
  logic [KEY_WIDTH-1:0]  r_core_key;
  logic [TEXT_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_err;

  logic                  w_start_ok;
  logic [ADDR_WIDTH:0]   w_count_next;

  // A legal count keeps pc within the ROM, so pc never needs to wrap.
  assign w_start_ok   = (num_blocks_i != '0) && (num_blocks_i <= CNT_MAX);
  assign w_count_next = r_count + CNT_ONE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the wide datapath registers are reset as well, because their
    // values are visible on the ports and must read 0 straight after reset.
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_out_index  <= '0;
      r_count      <= '0;
      r_num_blocks <= '0;
      r_core_text  <= '0;
      r_core_key   <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_start_ok) begin
              r_pc         <= '0;
              r_count      <= '0;
              r_num_blocks <= num_blocks_i;
              r_state      <= S_FETCH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          // ROM output was refreshed on this cycle's negedge from a stable pc.
          r_core_text <= rom_text_i;
          r_core_key  <= rom_key_i;
          r_state     <= S_LOAD;
        end
        S_LOAD: begin
          r_state <= S_WAIT_CORE;
        end
        S_WAIT_CORE: begin
          if (core_done_i) begin
            r_out_data  <= core_plain_i;
            r_out_index <= r_pc;
            r_out_valid <= 1'b1;
            r_state     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_count     <= w_count_next;
            if (w_count_next == r_num_blocks) begin
              r_state <= S_FINISH;
            end else begin
              r_pc    <= r_pc + PC_ONE;
              r_state <= S_FETCH;
            end
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc_o        = r_pc;
  assign core_text_o = r_core_text;
  assign core_key_o  = r_core_key;
  assign out_data_o  = r_out_data;
  assign out_index_o = r_out_index;
  assign out_valid_o = r_out_valid;
  assign err_o       = r_err;
  // Strobes decoded from state drop to 0 the moment reset forces IDLE.
  assign core_load_o = (r_state == S_LOAD);
  assign done_o      = (r_state == S_FINISH);
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes_dec_fetch_ctrl.sv
// Bench for aes_dec_fetch_ctrl: ROM and core models plus a block-sequence
// scoreboard, driven by directed cases and randomized runs.
module tb_aes_dec_fetch_ctrl;

  localparam int AW = 4;
  localparam int TW = 128;
  localparam int KW = 128;
  localparam int MS = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW:0]   num_blocks_i;
  logic [AW-1:0] pc_o;
  logic [TW-1:0] rom_text_i;
  logic [KW-1:0] rom_key_i;
  logic          core_load_o;
  logic [TW-1:0] core_text_o;
  logic [KW-1:0] core_key_o;
  logic          core_done_i;
  logic [TW-1:0] core_plain_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [TW-1:0] out_data_o;
  logic [AW-1:0] out_index_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  aes_dec_fetch_ctrl #(
    .ADDR_WIDTH(AW), .TEXT_WIDTH(TW), .KEY_WIDTH(KW), .MEMORY_SIZE(MS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .num_blocks_i(num_blocks_i),
    .pc_o(pc_o), .rom_text_i(rom_text_i), .rom_key_i(rom_key_i),
    .core_load_o(core_load_o), .core_text_o(core_text_o), .core_key_o(core_key_o),
    .core_done_i(core_done_i), .core_plain_i(core_plain_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_index_o(out_index_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ROM contents and the reference for every block: plaintext = text ^ key.
  logic [TW-1:0] rom_text_mem [MS];
  logic [KW-1:0] rom_key_mem  [MS];

  function automatic logic [TW-1:0] exp_plain(input int i);
    return rom_text_mem[i % MS] ^ rom_key_mem[i % MS];
  endfunction

  // ROM reads on the negedge from the current address.
  initial begin
    rom_text_i = '0;
    rom_key_i  = '0;
    forever begin
      @(negedge clk_i);
      rom_text_i = rom_text_mem[pc_o];
      rom_key_i  = rom_key_mem[pc_o];
    end
  end

  // Core model: done pulse a programmable number of cycles after the load.
  int core_lat_min = 1;
  int core_lat_max = 1;
  bit spurious     = 1'b0;

  initial begin
    int            pend;
    logic [TW-1:0] pplain;
    pend         = 0;
    pplain       = '0;
    core_done_i  = 1'b0;
    core_plain_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      core_done_i = 1'b0;
      if (rst_i) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            core_done_i  = 1'b1;
            core_plain_i = pplain;
          end
        end else if (spurious && $urandom_range(0, 3) == 0) begin
          core_done_i  = 1'b1;
          core_plain_i = {$urandom, $urandom, $urandom, $urandom};
        end
        if (core_load_o) begin
          pend   = $urandom_range(core_lat_min, core_lat_max);
          pplain = core_text_o ^ core_key_o;
        end
      end
    end
  end

  // Scoreboard: blocks must be loaded and emitted as indices 0..run_n-1 in order.
  int            exp_out  = 0;
  int            exp_load = 0;
  int            run_n    = 0;
  int            n_dones  = 0;
  int            n_loads  = 0;
  bit            prev_stall = 1'b0;
  logic [TW-1:0] prev_data;
  logic [AW-1:0] prev_idx;

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (core_load_o) begin
        n_loads++;
        check("load_pc", pc_o, exp_load);
        check("load_text", core_text_o, rom_text_mem[exp_load % MS]);
        check("load_key", core_key_o, rom_key_mem[exp_load % MS]);
        check("load_before_accept", exp_load, exp_out);
        exp_load++;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid_o, 1);
        check("stall_data", out_data_o, prev_data);
        check("stall_index", out_index_o, prev_idx);
      end
      if (out_valid_o) begin
        if (!prev_stall) begin
          check("out_index", out_index_o, exp_out);
          check("out_data", out_data_o, exp_plain(exp_out));
        end
        prev_stall = !out_ready_i;
        prev_data  = out_data_o;
        prev_idx   = out_index_o;
        if (out_ready_i) exp_out++;
      end else begin
        prev_stall = 1'b0;
      end
      if (done_o) begin
        n_dones++;
        check("done_after_all_out", exp_out, run_n);
        check("done_valid_low", out_valid_o, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < MS; i++) begin
      rom_text_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      rom_key_mem[i]  = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic sb_clear(input int n);
    exp_out  = 0;
    exp_load = 0;
    run_n    = n;
    n_dones  = 0;
  endtask

  // Start a run of n blocks and step until done_o; cycles counts from FETCH.
  task automatic run_blocks(input int n, input int ready_pct, input bit spur, output int cycles);
    bit fin;
    int loads0;
    fin    = 1'b0;
    cycles = 0;
    loads0 = n_loads;
    sb_clear(n);
    num_blocks_i = (AW + 1)'(n);
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    while (!fin && cycles < 3000) begin
      if (done_o) begin
        fin = 1'b1;
      end else begin
        out_ready_i = ($urandom_range(1, 100) <= ready_pct);
        if (spur) begin
          start_i      = ($urandom_range(0, 3) == 0);
          num_blocks_i = (AW + 1)'($urandom_range(0, 31));
        end
        tick();
        cycles++;
      end
    end
    start_i = 1'b0;
    check("run_finished", fin, 1);
    check("run_outputs", exp_out, n);
    check("run_loads", n_loads - loads0, n);
    tick();
    check("run_done_once", n_dones, 1);
    check("run_idle", busy_o, 0);
    check("run_pc_last", pc_o, n - 1);
    check("run_valid_low", out_valid_o, 0);
  endtask

  initial begin
    int cyc;
    int loads0;
    int c;
    logic [TW-1:0] held;

    rst_i        = 1'b1;
    start_i      = 1'b0;
    num_blocks_i = '0;
    out_ready_i  = 1'b0;
    fill_rom();
    #22;
    rst_i = 1'b0;
    tick();

    // Reset state.
    check("rst_pc", pc_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_core_text", core_text_o, 0);
    check("rst_core_key", core_key_o, 0);
    check("rst_out_data", out_data_o, 0);
    check("rst_done_err_load", {done_o, err_o, core_load_o}, 0);

    // Illegal starts.
    loads0 = n_loads;
    num_blocks_i = 5'd0;
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    check("err0_pulse", err_o, 1);
    check("err0_busy", busy_o, 0);
    tick();
    check("err0_clear", err_o, 0);
    num_blocks_i = 5'd17;
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    check("err17_pulse", err_o, 1);
    check("err17_busy", busy_o, 0);
    tick();
    check("err17_clear", err_o, 0);
    check("err_pc", pc_o, 0);
    check("err_no_load", n_loads - loads0, 0);

    // Single block with hand-computed values.
    rom_text_mem[0] = {16{8'hA5}};
    rom_key_mem[0]  = {16{8'h0F}};
    core_lat_min = 10;
    core_lat_max = 10;
    sb_clear(1);
    out_ready_i  = 1'b1;
    num_blocks_i = 5'd1;
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    check("single_fetch_no_load", core_load_o, 0);
    check("single_busy", busy_o, 1);
    tick();
    check("single_load", core_load_o, 1);
    check("single_text", core_text_o, {16{8'hA5}});
    check("single_key", core_key_o, {16{8'h0F}});
    c = 0;
    while (!out_valid_o && c < 30) begin
      tick();
      c++;
    end
    check("single_valid", out_valid_o, 1);
    check("single_index", out_index_o, 0);
    check("single_data", out_data_o, {16{8'hAA}});
    tick();
    check("single_done", done_o, 1);
    tick();
    check("single_idle", busy_o, 0);
    check("single_done_clear", done_o, 0);

    // Full sweep at the minimum of 4 cycles per block.
    fill_rom();
    core_lat_min = 1;
    core_lat_max = 1;
    run_blocks(16, 100, 1'b0, cyc);
    check("sweep_cycles", cyc, 64);

    // Backpressure: five stalled cycles on the first output.
    fill_rom();
    sb_clear(2);
    out_ready_i  = 1'b0;
    num_blocks_i = 5'd2;
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    c = 0;
    while (!out_valid_o && c < 30) begin
      tick();
      c++;
    end
    check("bp_valid", out_valid_o, 1);
    held   = out_data_o;
    loads0 = n_loads;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", out_valid_o, 1);
      check("bp_hold_data", out_data_o, held);
      check("bp_hold_pc", pc_o, 0);
    end
    out_ready_i = 1'b1;
    tick();
    check("bp_released", out_valid_o, 0);
    check("bp_no_early_load", n_loads - loads0, 0);
    c = 0;
    while (!done_o && c < 50) begin
      tick();
      c++;
    end
    check("bp_done", done_o, 1);
    check("bp_outputs", exp_out, 2);
    tick();

    // Reset while waiting on the core for the third block.
    fill_rom();
    core_lat_min = 10;
    core_lat_max = 10;
    sb_clear(5);
    num_blocks_i = 5'd5;
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    c = 0;
    while (exp_load < 3 && c < 200) begin
      tick();
      c++;
    end
    check("rstmid_reached", exp_load, 3);
    #2;
    rst_i = 1'b1;
    #1;
    check("rstmid_pc", pc_o, 0);
    check("rstmid_core", {core_text_o, core_load_o}, 0);
    check("rstmid_key", core_key_o, 0);
    check("rstmid_out", {out_data_o, out_valid_o}, 0);
    check("rstmid_flags", {busy_o, done_o, err_o, out_index_o}, 0);
    tick();
    rst_i = 1'b0;
    tick();
    check("rstmid_no_done", n_dones, 0);
    core_lat_min = 1;
    core_lat_max = 3;
    run_blocks(3, 100, 1'b0, cyc);

    // Randomized runs with backpressure, spurious done and start pulses.
    core_lat_min = 1;
    core_lat_max = 6;
    spurious     = 1'b1;
    for (int r = 0; r < 8; r++) begin
      fill_rom();
      run_blocks($urandom_range(1, 16), $urandom_range(30, 100), 1'b1, cyc);
    end
    spurious = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_dec_fetch_ctrl.md
Name: aes_dec_fetch_ctrl

Overview:
- Sequencer between the ciphertext/key ROM and the AES-128 decryption core.
- Drives the ROM address (pc), waits out the ROM's negedge read, and loads each ciphertext block plus key into the core.
- Waits for core completion, then presents each plaintext block downstream on a valid/ready handshake.
- Stops after a programmed number of blocks.

Parameters:
- ADDR_WIDTH, 4, ROM address width (pc width).
- TEXT_WIDTH, 128, ciphertext/plaintext block width.
- KEY_WIDTH, 128, key width.
- MEMORY_SIZE, 16, number of ciphertext entries in ROM; upper bound for block count.

Ports:
- clk_i  in  1  system clock, posedge; ROM reads on negedge of same clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request, sampled in IDLE only.
- num_blocks_i  in  ADDR_WIDTH+1  blocks to process; valid range 1..MEMORY_SIZE.
- pc_o  out  ADDR_WIDTH  ROM address.
- rom_text_i  in  TEXT_WIDTH  ROM ciphertext output.
- rom_key_i  in  KEY_WIDTH  ROM key output.
- core_load_o  out  1  one-cycle load strobe to the decryption core.
- core_text_o  out  TEXT_WIDTH  registered ciphertext to core.
- core_key_o  out  KEY_WIDTH  registered key to core.
- core_done_i  in  1  core completion pulse.
- core_plain_i  in  TEXT_WIDTH  core plaintext; valid while core_done_i=1.
- out_valid_o  out  1  plaintext valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  TEXT_WIDTH  plaintext block.
- out_index_o  out  ADDR_WIDTH  ROM index of out_data_o.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse after the last block is accepted.
- err_o  out  1  one-cycle pulse on rejected start.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: all outputs 0, including pc_o, core_text_o, core_key_o and out_data_o. State IDLE, block counter 0.
- Reset mid-operation: immediate return to IDLE. No done_o; any pending out_valid_o is dropped.
- States: IDLE, FETCH, LOAD, WAIT_CORE, OUTPUT, FINISH.
- IDLE, start_i=1 with num_blocks_i in 1..MEMORY_SIZE:
  - pc_o<=0, count<=0, go to FETCH.
- IDLE, start_i=1 with num_blocks_i=0 or >MEMORY_SIZE:
  - err_o=1 for one cycle; stay IDLE.
- IDLE, start_i=0: hold.
- FETCH (exactly 1 cycle): pc_o is stable from the preceding posedge, and the ROM latches on this cycle's negedge. At the next posedge:
  - core_text_o<=rom_text_i, core_key_o<=rom_key_i;
  - go to LOAD.
- LOAD (exactly 1 cycle): core_load_o=1, go to WAIT_CORE. core_load_o is high only in LOAD.
- WAIT_CORE: hold until core_done_i=1, no timeout. Then:
  - out_data_o<=core_plain_i, out_index_o<=pc_o, out_valid_o<=1;
  - go to OUTPUT.
  - core_done_i in any other state is ignored.
- OUTPUT: out_valid_o, out_data_o and out_index_o hold stable until out_ready_i=1. On the handshake cycle:
  - out_valid_o<=0, count<=count+1;
  - if count+1==num_blocks_q, go to FINISH;
  - else pc_o<=pc_o+1 and go to FETCH.
- FINISH (1 cycle): done_o=1, then IDLE. pc_o holds the last index until the next start.
- num_blocks_i is captured into num_blocks_q at start; later changes are ignored.
- start_i outside IDLE is ignored.
- pc_o never wraps: its maximum is MEMORY_SIZE-1, guaranteed by the range check. The counter is ADDR_WIDTH+1 bits wide so MEMORY_SIZE is representable.
- Key is reloaded from ROM with every block.
- Minimum per-block latency, start (or handshake) to core_load_o: 2 cycles (FETCH, LOAD).
- Minimum throughput: 4 cycles/block with instant core_done_i and out_ready_i.

Test Plan:
- Single block: num_blocks_i=1, ROM[0]=A, key=K, core_done_i 10 cycles after load, out_ready_i=1 → core_load_o high exactly 2 cycles after start with core_text_o=A, core_key_o=K; out_valid_o with out_index_o=0; done_o pulse next cycle; busy_o drops.
- Full sweep: num_blocks_i=16, core_done_i 1 cycle after load → 16 core_load_o pulses, pc_o 0..15, out_index_o 0..15 in order, one done_o, pc_o ends at 15.
- Backpressure: out_ready_i low for 5 cycles in OUTPUT → out_valid_o and out_data_o stable all 5 cycles; pc_o does not advance; no second core_load_o until the handshake.
- Illegal start: num_blocks_i=0, then 17 → err_o one-cycle pulse each; busy_o stays 0; pc_o stays 0; no core_load_o.
- Reset mid-run: rst_i asserted in WAIT_CORE of block 3 → all outputs 0 at once, asynchronously; a later start restarts at pc_o=0.
- Spurious inputs: core_done_i and start_i pulsed during FETCH/OUTPUT → ignored; block sequence and count unchanged.
